// File: rtl/kme_clk_run_pkg.sv
// -----------------------------------------------------------------------------
// kme_clk_run_pkg
// Shared types and default widths for the KME run-control stage.
//   cmd_op_e : encoding of the cmd_op bus (STOP / RUN_FREE / RUN_N / STEP)
//   state_e  : run-control state (IDLE / RUN_FREE / RUN_N)
// -----------------------------------------------------------------------------
package kme_clk_run_pkg;

    localparam int CNT_W_DEF     = 32;
    localparam int CYC_W_DEF     = 64;
    localparam int HALT_SRCS_DEF = 4;

    typedef enum logic [1:0] {
        OP_STOP     = 2'd0,
        OP_RUN_FREE = 2'd1,
        OP_RUN_N    = 2'd2,
        OP_STEP     = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN_FREE = 2'd1,
        ST_RUN_N    = 2'd2
    } state_e;

endpackage

// File: rtl/kme_run_cnt.sv
// -----------------------------------------------------------------------------
// kme_run_cnt
// Loadable down-counter holding the cycles left in a RUN_N / STEP run.
// Ports:
//   clk, rst_n : master clock, asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one (saturates at zero)
//   count      : current count
//   zero       : count == 0
//   last       : count == 1, i.e. the current enabled cycle is the final one
// -----------------------------------------------------------------------------
module kme_run_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero,
    output logic         last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
    assign last = (count == W'(1));

endmodule

// File: rtl/kme_clk_run_ctrl.sv
// -----------------------------------------------------------------------------
// kme_clk_run_ctrl
// Run control for the KME DUT clock: produces a registered clock enable that
// lets the bench run free, run exactly N cycles, single-step, or halt on a
// STOP command or an external breakpoint. Counts every enabled cycle.
// Ports:
//   clk         : master clock (only clock in the block)
//   rst_n       : asynchronous active-low reset
//   cmd_valid   : command strobe
//   cmd_ready   : command accepted when cmd_valid && cmd_ready (low in reset)
//   cmd_op      : 0=STOP 1=RUN_FREE 2=RUN_N 3=STEP
//   cmd_cycles  : cycle count for RUN_N
//   halt_req    : level-sensitive breakpoint requests, any bit halts a run
//   clk_en      : registered DUT clock enable
//   running     : high in RUN_FREE or RUN_N
//   done        : one-cycle pulse when RUN_N or STEP completes
//   halted      : sticky halt flag, cleared by the next accepted run command
//   halt_cause  : halt_req bits captured at halt, zero for STOP
//   remaining   : cycles left in the current RUN_N
//   cycle_count : total enabled cycles, wraps silently
// -----------------------------------------------------------------------------
module kme_clk_run_ctrl
    import kme_clk_run_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int CYC_W     = CYC_W_DEF,
    parameter int HALT_SRCS = HALT_SRCS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CNT_W-1:0]     cmd_cycles,
    input  logic [HALT_SRCS-1:0] halt_req,
    output logic                 clk_en,
    output logic                 running,
    output logic                 done,
    output logic                 halted,
    output logic [HALT_SRCS-1:0] halt_cause,
    output logic [CNT_W-1:0]     remaining,
    output logic [CYC_W-1:0]     cycle_count
);

    state_e               state;
    state_e               state_nxt;
    cmd_op_e              op;
    logic                 cmd_fire;
    logic                 halt_any;
    logic                 clk_en_nxt;
    logic                 done_nxt;
    logic                 halted_nxt;
    logic [HALT_SRCS-1:0] cause_nxt;
    logic                 cnt_load;
    logic [CNT_W-1:0]     cnt_load_val;
    logic                 cnt_dec;
    logic                 cnt_zero;
    logic                 cnt_last;

    // Ready is simply "out of reset": every command is accepted immediately.
    assign cmd_ready = rst_n;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign op        = cmd_op_e'(cmd_op);
    assign halt_any  = |halt_req;
    assign running   = (state != ST_IDLE);

    // An enabled RUN_N cycle consumes one count even if a STOP or halt lands
    // in that same cycle; a new RUN_N/STEP load overrides the decrement.
    assign cnt_dec = (state == ST_RUN_N) && clk_en;

    kme_run_cnt #(
        .W (CNT_W)
    ) u_run_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (remaining),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    // Priority: accepted command > RUN_N completion > breakpoint halt.
    always_comb begin
        state_nxt    = state;
        done_nxt     = 1'b0;
        halted_nxt   = halted;
        cause_nxt    = halt_cause;
        cnt_load     = 1'b0;
        cnt_load_val = cmd_cycles;

        if (cmd_fire) begin
            case (op)
                OP_STOP: begin
                    state_nxt  = ST_IDLE;
                    halted_nxt = 1'b1;
                    cause_nxt  = '0;
                end
                OP_RUN_FREE: begin
                    state_nxt  = ST_RUN_FREE;
                    halted_nxt = 1'b0;
                    cause_nxt  = '0;
                end
                OP_RUN_N: begin
                    cnt_load   = 1'b1;
                    halted_nxt = 1'b0;
                    cause_nxt  = '0;
                    // A zero-length run completes immediately without enabling.
                    if (cmd_cycles == '0) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_RUN_N;
                    end
                end
                OP_STEP: begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(1);
                    state_nxt    = ST_RUN_N;
                    halted_nxt   = 1'b0;
                    cause_nxt    = '0;
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end else if ((state == ST_RUN_N) && (cnt_last || cnt_zero)) begin
            // Completion beats a breakpoint arriving on the final cycle.
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
        end else if ((state != ST_IDLE) && halt_any) begin
            state_nxt  = ST_IDLE;
            halted_nxt = 1'b1;
            cause_nxt  = halt_req;
        end

        clk_en_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            clk_en     <= 1'b0;
            done       <= 1'b0;
            halted     <= 1'b0;
            halt_cause <= '0;
        end else begin
            state      <= state_nxt;
            clk_en     <= clk_en_nxt;
            done       <= done_nxt;
            halted     <= halted_nxt;
            halt_cause <= cause_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if (clk_en) begin
            cycle_count <= cycle_count + CYC_W'(1);
        end
    end

endmodule
